ram_bist_master: RTL and testbench

- Initiator side of the 4-word x 4-bit switch-driven RAM port.
- On a start pulse it drives the RAM's enable, read-enable, address and write-data lines to write a known pattern into every word.
- It then reads each word back, compares it against the expected value, and reports pass/fail, the error count and the first failing address.
- It replaces manual switch operation for board self-test of the RAM block.

---
 rtl/ram_bist_master.sv | 197 +++++++++++++++++++
 tb/tb_ram_bist_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_master.sv
// Self-test initiator for the small switch-driven RAM port:
// writes a known pattern, reads it back and reports mismatches.
module ram_bist_master #(
    parameter int                ADDR_W = 2,
    parameter int                DATA_W = 4,
    parameter logic [DATA_W-1:0] SEED   = 4'h5,
    parameter logic [DATA_W-1:0] STEP   = 4'h3
) (
    input  logic              row1_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pat_inv,
    output logic              ram_en,
    output logic              r_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [3:0]        status_led
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W:0]   MAX_ERR = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CMP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_start_d;
    logic                r_inv;
    logic                w_inv_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                r_ram_en;
    logic                w_ram_en_nxt;
    logic                r_r_en;
    logic                w_r_en_nxt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_pass;
    logic                w_pass_nxt;
    logic [ADDR_W:0]     r_err_cnt;
    logic [ADDR_W:0]     w_err_cnt_nxt;
    logic [ADDR_W-1:0]   r_first_err;
    logic [ADDR_W-1:0]   w_first_err_nxt;
    logic [3:0]          r_led;
    logic [3:0]          w_led_nxt;
    logic                w_start_rise;
    logic                w_launch;
    logic                w_mis;

    function automatic logic [DATA_W-1:0] f_pat(
        input logic [ADDR_W-1:0] a,
        input logic              inv
    );
        logic [DATA_W-1:0] v;
        v = SEED + DATA_W'(a) * STEP;
        return inv ? ~v : v;
    endfunction

    assign w_start_rise = start & ~r_start_d;
    assign w_launch     = w_start_rise &&
                          (r_state == S_IDLE || r_state == S_DONE);
    assign w_mis        = (r_state == S_CMP) &&
                          (ram_rdata != f_pat(r_addr, r_inv));

    always_ff @(posedge row1_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b1;
            r_inv       <= 1'b0;
            r_addr      <= '0;
            r_ram_en    <= 1'b0;
            r_r_en      <= 1'b0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_led       <= 4'b1111;
        end else begin
            r_state     <= w_state_nxt;
            r_start_d   <= start;
            r_inv       <= w_inv_nxt;
            r_addr      <= w_addr_nxt;
            r_ram_en    <= w_ram_en_nxt;
            r_r_en      <= w_r_en_nxt;
            r_wdata     <= w_wdata_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_first_err <= w_first_err_nxt;
            r_led       <= w_led_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_inv_nxt   = r_inv;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_launch) begin
                    w_state_nxt = S_WR;
                    w_addr_nxt  = '0;
                    w_inv_nxt   = pat_inv;
                end
            end
            S_WR: begin
                if (r_addr == LAST) begin
                    w_state_nxt = S_RD;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                end
            end
            S_RD: w_state_nxt = S_CMP;
            S_CMP: begin
                if (r_addr == LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RD;
                    w_addr_nxt  = r_addr + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        w_ram_en_nxt    = 1'b0;
        w_r_en_nxt      = r_r_en;
        w_wdata_nxt     = r_wdata;
        case (w_state_nxt)
            S_WR: begin
                w_ram_en_nxt = 1'b1;
                w_r_en_nxt   = 1'b0;
                w_wdata_nxt  = f_pat(w_addr_nxt, w_inv_nxt);
            end
            S_RD: begin
                w_ram_en_nxt = 1'b1;
                w_r_en_nxt   = 1'b1;
            end
            default: ;
        endcase

        w_busy_nxt = (w_state_nxt == S_WR) || (w_state_nxt == S_RD) ||
                     (w_state_nxt == S_CMP);
        w_done_nxt = (w_state_nxt == S_DONE);

        w_err_cnt_nxt   = r_err_cnt;
        w_first_err_nxt = r_first_err;
        if (w_launch) begin
            w_err_cnt_nxt   = '0;
            w_first_err_nxt = '0;
        end else if (w_mis) begin
            if (r_err_cnt < MAX_ERR)
                w_err_cnt_nxt = r_err_cnt + 1'b1;
            if (r_err_cnt == '0)
                w_first_err_nxt = r_addr;
        end

        w_pass_nxt = w_done_nxt && (w_err_cnt_nxt == '0);
        w_led_nxt  = ~{w_busy_nxt, w_done_nxt, w_pass_nxt,
                       w_done_nxt & ~w_pass_nxt};
    end

    assign ram_en         = r_ram_en;
    assign r_en           = r_r_en;
    assign ram_addr       = r_addr;
    assign ram_wdata      = r_wdata;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err;
    assign status_led     = r_led;

endmodule

// File: tb/tb_ram_bist_master.sv
// Bench for ram_bist_master: RAM responder with injectable stuck bits,
// table-driven and randomized tests against a pattern-level model.
module tb_ram_bist_master;

    logic       row1_clk;
    logic       rst;
    logic       start;
    logic       pat_inv;
    logic       ram_en;
    logic       r_en;
    logic [1:0] ram_addr;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] first_err_addr;
    logic [3:0] status_led;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] mem   [4];
    logic [3:0] and_m [4];
    logic [3:0] or_m  [4];

    typedef struct packed {
        logic        inv;
        logic [15:0] am;
        logic [15:0] om;
        logic [2:0]  e_err;
        logic [1:0]  e_first;
        logic        e_pass;
    } vec_t;

    vec_t tbl [6];

    ram_bist_master dut (
        .row1_clk       (row1_clk),
        .rst            (rst),
        .start          (start),
        .pat_inv        (pat_inv),
        .ram_en         (ram_en),
        .r_en           (r_en),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .status_led     (status_led)
    );

    initial row1_clk = 1'b0;
    always #5 row1_clk = ~row1_clk;

    // Responder: read data registered one clock after the request.
    always @(posedge row1_clk) begin
        if (ram_en) begin
            if (!r_en)
                mem[ram_addr] <= ram_wdata;
            else
                ram_rdata <= (mem[ram_addr] & and_m[ram_addr]) |
                             or_m[ram_addr];
        end
    end

    function automatic logic [3:0] pat(input int a, input logic inv);
        int v;
        v = (5 + 3 * a) % 16;
        return inv ? 4'(15 - v) : 4'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic set_faults(input logic [15:0] am, input logic [15:0] om);
        for (int i = 0; i < 4; i++) begin
            and_m[i] = am[4*i +: 4];
            or_m[i]  = om[4*i +: 4];
        end
    endtask

    task automatic run_test(input logic inv, input logic [15:0] am,
                            input logic [15:0] om, input int e_err,
                            input int e_first, input logic e_pass,
                            input bit pulse);
        int j;
        set_faults(am, om);
        @(negedge row1_clk);
        pat_inv = inv;
        start   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge row1_clk);
            if (k == 0) start = 1'b0;
            if (pulse && k == 1) begin
                start   = 1'b1;
                pat_inv = ~inv;
            end
            if (pulse && k == 2) start = 1'b0;
            chk($sformatf("k%0d_busy", k), 32'(busy), 32'd1);
            chk($sformatf("k%0d_done", k), 32'(done), 32'd0);
            if (k == 0) begin
                chk("k0_err_clr", 32'(err_cnt), 32'd0);
                chk("k0_first_clr", 32'(first_err_addr), 32'd0);
                chk("k0_pass", 32'(pass), 32'd0);
                chk("k0_led", 32'(status_led), 32'b0111);
            end
            if (k < 4) begin
                chk($sformatf("wr%0d_en", k), 32'(ram_en), 32'd1);
                chk($sformatf("wr%0d_ren", k), 32'(r_en), 32'd0);
                chk($sformatf("wr%0d_addr", k), 32'(ram_addr), 32'(k));
                chk($sformatf("wr%0d_data", k), 32'(ram_wdata),
                    32'(pat(k, inv)));
            end else begin
                j = k - 4;
                chk($sformatf("rd%0d_en", k), 32'(ram_en),
                    32'((j % 2) == 0));
                chk($sformatf("rd%0d_ren", k), 32'(r_en), 32'd1);
                chk($sformatf("rd%0d_addr", k), 32'(ram_addr), 32'(j / 2));
                chk($sformatf("rd%0d_wdata", k), 32'(ram_wdata),
                    32'(pat(3, inv)));
            end
        end
        @(negedge row1_clk);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_en", 32'(ram_en), 32'd0);
        chk("fin_err", 32'(err_cnt), 32'(e_err));
        chk("fin_first", 32'(first_err_addr), 32'(e_first));
        chk("fin_pass", 32'(pass), 32'(e_pass));
        chk("fin_led", 32'(status_led),
            32'(~{1'b0, 1'b1, e_pass, ~e_pass}) & 32'hF);
        @(negedge row1_clk);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_err", 32'(err_cnt), 32'(e_err));
    endtask

    initial begin
        logic       rinv;
        logic [15:0] am;
        logic [15:0] om;
        int         e_err;
        int         e_first;
        logic [3:0] p;
        logic [3:0] rd;

        for (int i = 0; i < 4; i++) mem[i] = 4'h0;
        ram_rdata = 4'h0;
        set_faults(16'hFFFF, 16'h0000);

        // inv, and-masks, or-masks, err, first, pass
        tbl[0] = '{1'b0, 16'hFFFF, 16'h0000, 3'd0, 2'd0, 1'b1};
        tbl[1] = '{1'b1, 16'hFFFF, 16'h0000, 3'd0, 2'd0, 1'b1};
        tbl[2] = '{1'b0, 16'hF7FF, 16'h0000, 3'd1, 2'd2, 1'b0};
        tbl[3] = '{1'b0, 16'h0000, 16'h0000, 3'd4, 2'd0, 1'b0};
        tbl[4] = '{1'b1, 16'hFFFF, 16'h8000, 3'd1, 2'd3, 1'b0};
        tbl[5] = '{1'b1, 16'h0F0F, 16'h0000, 3'd2, 2'd1, 1'b0};

        rst     = 1'b1;
        start   = 1'b0;
        pat_inv = 1'b0;
        #1;
        chk("rst_en", 32'(ram_en), 32'd0);
        chk("rst_led", 32'(status_led), 32'hF);
        @(negedge row1_clk);
        @(negedge row1_clk);
        rst = 1'b0;
        @(negedge row1_clk);
        chk("idle_en", 32'(ram_en), 32'd0);
        chk("idle_ren", 32'(r_en), 32'd0);
        chk("idle_addr", 32'(ram_addr), 32'd0);
        chk("idle_wdata", 32'(ram_wdata), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_pass", 32'(pass), 32'd0);
        chk("idle_err", 32'(err_cnt), 32'd0);
        chk("idle_first", 32'(first_err_addr), 32'd0);
        chk("idle_led", 32'(status_led), 32'hF);

        for (int t = 0; t < 6; t++)
            run_test(tbl[t].inv, tbl[t].am, tbl[t].om, int'(tbl[t].e_err),
                     int'(tbl[t].e_first), tbl[t].e_pass, 1'b0);

        // Async reset during RD of address 1, start held across release.
        set_faults(16'hFFFF, 16'h0000);
        @(negedge row1_clk);
        pat_inv = 1'b0;
        start   = 1'b1;
        @(negedge row1_clk);
        start = 1'b0;
        repeat (6) @(negedge row1_clk);
        chk("pre_rst_rd1_en", 32'(ram_en), 32'd1);
        chk("pre_rst_rd1_addr", 32'(ram_addr), 32'd1);
        #1;
        start = 1'b1;
        rst   = 1'b1;
        #1;
        chk("arst_en", 32'(ram_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_led", 32'(status_led), 32'hF);
        @(negedge row1_clk);
        rst = 1'b0;
        repeat (3) @(negedge row1_clk);
        chk("held_start_busy", 32'(busy), 32'd0);
        chk("held_start_en", 32'(ram_en), 32'd0);
        chk("held_start_done", 32'(done), 32'd0);
        start = 1'b0;
        run_test(1'b0, 16'hFFFF, 16'h0000, 0, 0, 1'b1, 1'b0);

        // Fail first, then a restart from DONE with a second start while busy.
        run_test(1'b0, 16'h0000, 16'h0000, 4, 0, 1'b0, 1'b0);
        run_test(1'b1, 16'hFFFF, 16'h0000, 0, 0, 1'b1, 1'b1);

        for (int r = 0; r < 10; r++) begin
            rinv = 1'($urandom);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: begin am[4*i +: 4] = 4'hF;
                             om[4*i +: 4] = 4'h0; end
                    1: begin am[4*i +: 4] = 4'($urandom);
                             om[4*i +: 4] = 4'h0; end
                    2: begin am[4*i +: 4] = 4'hF;
                             om[4*i +: 4] = 4'($urandom); end
                    default: begin am[4*i +: 4] = 4'($urandom);
                                   om[4*i +: 4] = 4'($urandom); end
                endcase
            end
            e_err   = 0;
            e_first = 0;
            for (int a = 0; a < 4; a++) begin
                p  = pat(a, rinv);
                rd = (p & am[4*a +: 4]) | om[4*a +: 4];
                if (rd != p) begin
                    if (e_err == 0) e_first = a;
                    e_err++;
                end
            end
            run_test(rinv, am, om, e_err, e_first, e_err == 0,
                     bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
